// File: rtl/tiny_rv_pkg.sv
// -----------------------------------------------------------------------------
// tiny_rv_pkg
// Shared definitions for the tiny_rv exec-stage ALU: the major opcodes
// handled by the integer execute unit, the funct3 encoding of the RV32I ALU
// operations, the sequencer state type and small decode helpers.
// -----------------------------------------------------------------------------
package tiny_rv_pkg;

    // Major opcodes serviced by the integer execute unit
    localparam logic [6:0] RV_LUI    = 7'b0110111;
    localparam logic [6:0] RV_AUIPC  = 7'b0010111;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV_OP     = 7'b0110011;

    // funct3 encoding shared by OP and OP-IMM
    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } funct3_t;

    // Sequencer states of the execute unit
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    // True for the register/immediate ALU opcode groups
    function automatic logic is_alu_opcode(input logic [6:0] opcode);
        return (opcode == RV_OP_IMM) || (opcode == RV_OP);
    endfunction

    // True for the funct3 values that go through the iterative shifter
    function automatic logic is_shift_funct3(input funct3_t f3);
        return (f3 == SLL) || (f3 == SRL_SRA);
    endfunction

endpackage

// File: rtl/tiny_rv_exec_shifter.sv
// -----------------------------------------------------------------------------
// tiny_rv_exec_shifter
// Iterative shifter: moves up to SHIFT_STEP bit positions per step cycle
// until the loaded shift amount is used up.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset (clears the count)
//   load         in   capture load_value / load_amount / direction flags
//   load_value   in   XLEN  value to be shifted
//   load_amount  in   log2(XLEN)  total shift amount
//   load_left    in   1 = shift left, 0 = shift right
//   load_arith   in   right shifts fill with the sign bit when set
//   step         in   perform one shift step this cycle
//   value_next   out  XLEN  value after the current step (result when done)
//   done         out  the current step is the final one
// -----------------------------------------------------------------------------
module tiny_rv_exec_shifter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [XLEN-1:0]          load_value,
    input  logic [$clog2(XLEN)-1:0]  load_amount,
    input  logic                     load_left,
    input  logic                     load_arith,
    input  logic                     step,
    output logic [XLEN-1:0]          value_next,
    output logic                     done
);

    localparam int SHAMT_W = $clog2(XLEN);
    // One extra bit so the count can also represent SHIFT_STEP == XLEN
    localparam int CNT_W   = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(SHIFT_STEP);

    logic [XLEN-1:0]  value_q;
    logic [CNT_W-1:0] remain_q;
    logic             left_q;
    logic             arith_q;
    logic [CNT_W-1:0] step_amt;
    logic signed [XLEN-1:0] value_s;

    // The last step may be shorter than SHIFT_STEP
    assign step_amt = (remain_q < STEP_CNT) ? remain_q : STEP_CNT;
    assign done     = (remain_q <= STEP_CNT);
    assign value_s  = value_q;

    always_comb begin
        value_next = value_q;
        if (left_q) begin
            value_next = value_q << step_amt;
        end else if (arith_q) begin
            value_next = value_s >>> step_amt;
        end else begin
            value_next = value_q >> step_amt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_q <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
        end else if (load) begin
            remain_q <= {1'b0, load_amount};
            left_q   <= load_left;
            arith_q  <= load_arith;
        end else if (step) begin
            remain_q <= remain_q - step_amt;
        end
    end

    // Data register: no reset, only meaningful between load and done
    always_ff @(posedge clk) begin
        if (load) begin
            value_q <= load_value;
        end else if (step) begin
            value_q <= value_next;
        end
    end

endmodule

// File: rtl/tiny_rv_exec_alu_seq.sv
// -----------------------------------------------------------------------------
// tiny_rv_exec_alu_seq
// Handshaked integer execute unit for LUI, AUIPC, OP-IMM and OP. Single-cycle
// operations return one cycle after accept; shifts with a non-zero amount are
// handed to an iterative shifter and return once it has finished.
//
// Ports:
//   i_clk       in   clock, rising edge
//   i_rst       in   asynchronous active-high reset
//   i_valid     in   request valid
//   o_ready     out  request can be accepted this cycle
//   i_pc        in   XLEN  instruction PC
//   i_opcode    in   7     opcode
//   i_funct3    in   3     funct3
//   i_funct7_5  in   1     instruction bit 30 (SUB / SRA select)
//   i_rs1       in   XLEN  source operand 1
//   i_rs2       in   XLEN  source operand 2
//   i_imm       in   XLEN  decoded immediate
//   o_valid     out  result valid
//   i_ready     in   writeback accepts the result
//   o_result    out  XLEN  result
//   o_active    out  opcode was handled by this unit (qualified by o_valid)
// -----------------------------------------------------------------------------
module tiny_rv_exec_alu_seq
    import tiny_rv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7_5,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_active
);

    localparam int SHAMT_W = $clog2(XLEN);

    alu_state_t         state_q;
    alu_state_t         state_d;
    funct3_t            f3;
    logic [XLEN-1:0]    op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               req_is_shift;
    logic [XLEN-1:0]    alu_result;
    logic               alu_active;
    logic [XLEN-1:0]    shift_result;
    logic               shift_done;
    logic               ready;
    logic               load;
    logic               step;
    logic               res_we;
    logic               res_from_shifter;

    assign f3           = funct3_t'(i_funct3);
    assign op_b         = (i_opcode == RV_OP) ? i_rs2 : i_imm;
    assign shamt        = op_b[SHAMT_W-1:0];
    assign req_is_shift = is_alu_opcode(i_opcode) && is_shift_funct3(f3);

    // Single-cycle datapath. Shifts only reach this path with shamt == 0,
    // where the result is simply rs1.
    always_comb begin
        alu_result = '0;
        alu_active = 1'b0;
        if (i_opcode == RV_LUI) begin
            alu_result = i_imm;
            alu_active = 1'b1;
        end else if (i_opcode == RV_AUIPC) begin
            alu_result = i_pc + i_imm;
            alu_active = 1'b1;
        end else if (is_alu_opcode(i_opcode)) begin
            alu_active = 1'b1;
            case (f3)
                ADD_SUB: alu_result = ((i_opcode == RV_OP) && i_funct7_5)
                                      ? (i_rs1 - op_b) : (i_rs1 + op_b);
                SLT:     alu_result = {{(XLEN-1){1'b0}},
                                       ($signed(i_rs1) < $signed(op_b))};
                SLTU:    alu_result = {{(XLEN-1){1'b0}}, (i_rs1 < op_b)};
                XOR:     alu_result = i_rs1 ^ op_b;
                OR:      alu_result = i_rs1 | op_b;
                AND:     alu_result = i_rs1 & op_b;
                default: alu_result = i_rs1;
            endcase
        end
    end

    tiny_rv_exec_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk         (i_clk),
        .rst         (i_rst),
        .load        (load),
        .load_value  (i_rs1),
        .load_amount (shamt),
        .load_left   (f3 == SLL),
        .load_arith  (i_funct7_5),
        .step        (step),
        .value_next  (shift_result),
        .done        (shift_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control. DONE with i_ready behaves like IDLE for the
    // incoming request so non-shift ops sustain one result per cycle.
    always_comb begin
        state_d          = state_q;
        ready            = 1'b0;
        load             = 1'b0;
        step             = 1'b0;
        res_we           = 1'b0;
        res_from_shifter = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                step = 1'b1;
                if (shift_done) begin
                    state_d          = DONE;
                    res_we           = 1'b1;
                    res_from_shifter = 1'b1;
                end
            end
            DONE: begin
                ready = i_ready;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (i_valid && ready) begin
            if (req_is_shift && (shamt != '0)) begin
                load    = 1'b1;
                state_d = SHIFT;
            end else begin
                state_d = DONE;
                res_we  = 1'b1;
            end
        end
    end

    // Result registers only load on DONE entry, so they stay stable under
    // backpressure.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result <= '0;
            o_active <= 1'b0;
        end else if (res_we) begin
            o_result <= res_from_shifter ? shift_result : alu_result;
            o_active <= res_from_shifter ? 1'b1 : alu_active;
        end
    end

    assign o_ready = ready;
    assign o_valid = (state_q == DONE);

endmodule

// File: tb/tb_tiny_rv_exec_alu_seq.sv
module tb_tiny_rv_exec_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc, rs1, rs2, imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f75;

    logic        rdy1, vld1, act1;
    logic [31:0] res1;
    logic        rdy8, vld8, act8;
    logic [31:0] res8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tiny_rv_exec_alu_seq #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy1),
        .i_pc(pc), .i_opcode(opc), .i_funct3(f3), .i_funct7_5(f75),
        .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
        .o_valid(vld1), .i_ready(in_ready), .o_result(res1), .o_active(act1)
    );

    tiny_rv_exec_alu_seq #(.XLEN(32), .SHIFT_STEP(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy8),
        .i_pc(pc), .i_opcode(opc), .i_funct3(f3), .i_funct7_5(f75),
        .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
        .o_valid(vld8), .i_ready(in_ready), .o_result(res8), .o_active(act8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: whole-instruction semantics of the RV32I ALU subset
    function automatic logic ref_supported(input logic [6:0] o);
        return (o == 7'b0110111) || (o == 7'b0010111) ||
               (o == 7'b0010011) || (o == 7'b0110011);
    endfunction

    function automatic logic [31:0] ref_result(input logic [6:0] o, input logic [2:0] fn,
                                               input logic f7, input logic [31:0] p,
                                               input logic [31:0] a, input logic [31:0] r2,
                                               input logic [31:0] im);
        logic [31:0] b;
        int sh;
        logic signed [31:0] as;
        b  = (o == 7'b0110011) ? r2 : im;
        sh = int'(b % 32);
        as = a;
        if (o == 7'b0110111) return im;
        if (o == 7'b0010111) return p + im;
        if (o != 7'b0010011 && o != 7'b0110011) return 32'd0;
        case (fn)
            3'd0: return (o == 7'b0110011 && f7) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'(as >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_latency(input int stepw, input logic [6:0] o, input logic [2:0] fn,
                                       input logic [31:0] r2, input logic [31:0] im);
        int sh;
        sh = int'(((o == 7'b0110011) ? r2 : im) % 32);
        if ((o == 7'b0010011 || o == 7'b0110011) && (fn == 3'd1 || fn == 3'd5) && sh > 0)
            return 1 + (sh + stepw - 1) / stepw;
        return 1;
    endfunction

    // Issue one request to both units (called at a falling edge) and check
    // latency, result and active flag of each.
    task automatic do_txn(input string tag, input logic [6:0] o, input logic [2:0] fn,
                          input logic f7, input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] r2, input logic [31:0] im);
        int w;
        int l1, l8;
        logic [31:0] r1v, r8v;
        logic a1v, a8v;
        logic [31:0] er;
        w = 0;
        while (!(rdy1 && rdy8) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".ready"}, {63'd0, rdy1 && rdy8}, 64'd1);
        opc = o; f3 = fn; f75 = f7; pc = p; rs1 = a; rs2 = r2; imm = im;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        l1 = 0; l8 = 0; r1v = '0; r8v = '0; a1v = 1'b0; a8v = 1'b0;
        for (int c = 1; c <= 80 && (l1 == 0 || l8 == 0); c++) begin
            if (c > 1) @(negedge clk);
            if (vld1 && l1 == 0) begin l1 = c; r1v = res1; a1v = act1; end
            if (vld8 && l8 == 0) begin l8 = c; r8v = res8; a8v = act8; end
        end
        er = ref_result(o, fn, f7, p, a, r2, im);
        check({tag, ".lat1"}, 64'(l1), 64'(ref_latency(1, o, fn, r2, im)));
        check({tag, ".lat8"}, 64'(l8), 64'(ref_latency(8, o, fn, r2, im)));
        check({tag, ".res1"}, {32'd0, r1v}, {32'd0, er});
        check({tag, ".res8"}, {32'd0, r8v}, {32'd0, er});
        check({tag, ".act1"}, {63'd0, a1v}, {63'd0, ref_supported(o)});
        check({tag, ".act8"}, {63'd0, a8v}, {63'd0, ref_supported(o)});
    endtask

    initial begin
        logic [6:0]  ops [5];
        logic [31:0] exp_q [$];
        int          seen;

        ops[0] = 7'b0110111; ops[1] = 7'b0010111; ops[2] = 7'b0010011;
        ops[3] = 7'b0110011; ops[4] = 7'b1100011;

        rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
        pc = '0; rs1 = '0; rs2 = '0; imm = '0; opc = '0; f3 = '0; f75 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.vld1", {63'd0, vld1}, 64'd0);
        check("rst.res1", {32'd0, res1}, 64'd0);
        check("rst.act1", {63'd0, act1}, 64'd0);
        check("rst.rdy1", {63'd0, rdy1}, 64'd1);
        check("rst.vld8", {63'd0, vld8}, 64'd0);
        check("rst.res8", {32'd0, res8}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_txn("lui",   7'b0110111, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h12345000);
        do_txn("auipc", 7'b0010111, 3'd0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'hFFFFF000);
        do_txn("sub",   7'b0110011, 3'd0, 1'b1, 32'h0, 32'd5, 32'd7, 32'h0);
        do_txn("slt",   7'b0110011, 3'd2, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
        do_txn("sltu",  7'b0110011, 3'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
        do_txn("srai31",7'b0010011, 3'd5, 1'b1, 32'h0, 32'h80000000, 32'h0, 32'd31);
        do_txn("sll0",  7'b0110011, 3'd1, 1'b0, 32'h0, 32'hDEADBEEF, 32'h20, 32'h0);
        do_txn("slli9", 7'b0010011, 3'd1, 1'b0, 32'h0, 32'h00F0F00F, 32'h0, 32'd9);

        // Back-to-back ADDI with writeback always ready
        for (int k = 0; k < 8; k++) begin
            opc = 7'b0010011; f3 = 3'd0; f75 = 1'b0;
            rs1 = $urandom; imm = $urandom; rs2 = $urandom;
            exp_q.push_back(rs1 + imm);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("b2b.vld1", {63'd0, vld1}, 64'd1);
            check("b2b.res1", {32'd0, res1}, {32'd0, exp_q[k]});
            check("b2b.res8", {32'd0, res8}, {32'd0, exp_q[k]});
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: result held, new request ignored
        in_ready = 1'b0;
        opc = 7'b0110011; f3 = 3'd0; f75 = 1'b0; rs1 = 32'h11111111; rs2 = 32'h22222222;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rs1 = 32'h01010101; rs2 = 32'h5;
        for (int k = 0; k < 5; k++) begin
            check("bp.vld1", {63'd0, vld1}, 64'd1);
            check("bp.res1", {32'd0, res1}, 64'h33333333);
            check("bp.rdy1", {63'd0, rdy1}, 64'd0);
            check("bp.res8", {32'd0, res8}, 64'h33333333);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(negedge clk);
        check("bp.release", {63'd0, vld1}, 64'd0);

        // Reset in the middle of an SRL by 20
        opc = 7'b0110011; f3 = 3'd5; f75 = 1'b0; rs1 = 32'hF0000000; rs2 = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid.vld1", {63'd0, vld1}, 64'd0);
        #1 rst = 1'b1;
        #1;
        check("arst.res1", {32'd0, res1}, 64'd0);
        check("arst.act1", {63'd0, act1}, 64'd0);
        check("arst.res8", {32'd0, res8}, 64'd0);
        check("arst.vld1", {63'd0, vld1}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (vld1 || vld8) seen++;
        end
        check("arst.abandon", 64'(seen), 64'd0);
        do_txn("add23", 7'b0110011, 3'd0, 1'b0, 32'h0, 32'd2, 32'd3, 32'h0);
        do_txn("unsup", 7'b1100011, 3'd0, 1'b0, 32'h40, 32'h7, 32'h9, 32'h10);

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [6:0]  ro;
            logic [31:0] ra, rb;
            ro = ops[$urandom_range(4, 0)];
            ra = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) : 32'($urandom);
            rb = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(7, 0)) : 32'($urandom);
            do_txn("rand", ro, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                   32'($urandom), ra, rb, 32'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
